// File: rtl/md_pkg.sv
// md_pkg: opcodes, FSM state encoding and default latencies for the HI/LO multiply/divide engine.
package md_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/md_div_core.sv
// md_div_core: combinational 32-bit signed/unsigned divide; quotient truncates toward zero, remainder takes dividend sign.
module md_div_core (
    input  logic        isSigned,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divByZero
);
    logic [31:0] absN, absD, uq, ur;
    logic negQ, negR;
    always_comb begin
        negR = isSigned && dividend[31];
        negQ = isSigned && (dividend[31] ^ divisor[31]);
        absN = negR ? -dividend : dividend;
        absD = (isSigned && divisor[31]) ? -divisor : divisor;
        divByZero = divisor == 32'd0;
        // a zero divisor is replaced so the datapath never produces X; the result is discarded anyway
        if (divByZero) absD = 32'd1;
        uq = absN / absD;
        ur = absN % absD;
        quotient  = negQ ? -uq : uq;
        remainder = negR ? -ur : ur;
    end
endmodule

// File: rtl/hilo_md_engine.sv
// hilo_md_engine: fixed-latency multiply/divide unit owning the architectural HI/LO registers.
module hilo_md_engine
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    state_t state, nextState;
    logic [CW-1:0] count;
    logic [63:0] res, result, prodS, prodU, madd;
    logic [31:0] quot, rem;
    logic divByZero, isDiv, validOp, writeRes;

    md_div_core divCore (
        .isSigned (op == OP_DIV),
        .dividend (data1),
        .divisor  (data2),
        .quotient (quot),
        .remainder(rem),
        .divByZero(divByZero)
    );

    always_comb begin
        prodS = $signed(data1) * $signed(data2);
        prodU = {32'd0, data1} * {32'd0, data2};
        madd = {hi, lo} + prodS;
        isDiv = op == OP_DIV || op == OP_DIVU;
        validOp = op <= OP_MADD;
        result = op == OP_MULT ? prodS : op == OP_MULTU ? prodU : op == OP_MADD ? madd : {rem, quot};
        nextState = state == IDLE ? (start && validOp ? RUN : IDLE) : (count == CW'(1) ? IDLE : RUN);
    end

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= nextState;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            res <= '0;
            writeRes <= 1'b0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start && validOp) begin
                res <= result;
                count <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                writeRes <= !(isDiv && divByZero);
            end else if (!start) begin
                if (mthi) hi <= data1;
                if (mtlo) lo <= data1;
            end
        end else begin
            count <= count - CW'(1);
            done <= count == CW'(1);
            if (count == CW'(1) && writeRes) {hi, lo} <= res;
        end
    end

    assign busy = state == RUN;
endmodule
